bsg_manycore_loader_out_throttle: RTL and testbench

Credit-gated packet buffer between the SPMD loader and the I/O endpoint's outbound port. It accepts request packets from the loader over a valid/ready handshake and holds them in a small FIFO. It issues a packet to the endpoint only while the endpoint's outstanding-credit count exceeds a programmable reserve. It also keeps saturating statistics on sent packets and credit-stall cycles for end-of-test reporting.

---
 rtl/bsg_manycore_loader_out_throttle_if.sv | 29 ++
 rtl/bsg_manycore_loader_out_throttle.sv | 84 ++++++++
 tb/tb_bsg_manycore_loader_out_throttle.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bsg_manycore_loader_out_throttle_if.sv
// Handshake bundle between the SPMD loader, the throttle buffer and the endpoint outbound port.
// The slave modport is the throttle's view; the master modport is the surrounding logic's view.
interface bsg_manycore_loader_out_throttle_if #(
    parameter int packet_width_p         = 16,
    parameter int credit_counter_width_p = 4,
    parameter int count_width_p          = 32
);
    logic                              v_i;
    logic [packet_width_p-1:0]         packet_i;
    logic                              ready_o;
    logic                              v_o;
    logic [packet_width_p-1:0]         packet_o;
    logic                              ready_i;
    logic [credit_counter_width_p-1:0] out_credits_i;
    logic                              empty_o;
    logic                              credit_stall_o;
    logic [count_width_p-1:0]          sent_count_o;
    logic [count_width_p-1:0]          stall_count_o;

    modport slave (
        input  v_i, packet_i, ready_i, out_credits_i,
        output ready_o, v_o, packet_o, empty_o, credit_stall_o, sent_count_o, stall_count_o
    );

    modport master (
        output v_i, packet_i, ready_i, out_credits_i,
        input  ready_o, v_o, packet_o, empty_o, credit_stall_o, sent_count_o, stall_count_o
    );
endinterface

// File: rtl/bsg_manycore_loader_out_throttle.sv
// Credit-gated packet FIFO between the SPMD loader and the endpoint outbound port,
// with saturating sent-packet and credit-stall statistics.
module bsg_manycore_loader_out_throttle #(
    parameter int packet_width_p         = 16,
    parameter int credit_counter_width_p = 4,
    parameter int els_p                  = 4,
    parameter int credit_reserve_p       = 1,
    parameter int count_width_p          = 32
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    bsg_manycore_loader_out_throttle_if.slave io
);
    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [packet_width_p-1:0] r_mem [els_p];
    logic [ptr_w_lp-1:0]       r_wr_ptr;
    logic [ptr_w_lp-1:0]       r_rd_ptr;
    logic [cnt_w_lp-1:0]       r_count;
    logic [count_width_p-1:0]  r_sent_count;
    logic [count_width_p-1:0]  r_stall_count;

    logic w_credit_ok;
    logic w_not_empty;
    logic w_ready;
    logic w_valid;
    logic w_enq;
    logic w_deq;
    logic w_stall;

    always_comb begin
        w_credit_ok = io.out_credits_i > credit_counter_width_p'(credit_reserve_p);
        w_not_empty = (r_count != '0);
        // No full-plus-dequeue bypass: keeps ready_o independent of the endpoint side.
        w_ready     = reset_n_i & (r_count != cnt_w_lp'(els_p));
        w_valid     = w_not_empty & w_credit_ok;
        w_enq       = io.v_i & w_ready;
        w_deq       = w_valid & io.ready_i;
        w_stall     = w_not_empty & ~w_credit_ok;
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= io.packet_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_sent_count  <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + ptr_w_lp'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + ptr_w_lp'(1);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + cnt_w_lp'(1);
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - cnt_w_lp'(1);
            end
            if (w_deq && (r_sent_count != '1)) begin
                r_sent_count <= r_sent_count + count_width_p'(1);
            end
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + count_width_p'(1);
            end
        end
    end

    assign io.ready_o        = w_ready;
    assign io.v_o            = w_valid;
    assign io.packet_o       = w_valid ? r_mem[r_rd_ptr] : '0;
    assign io.empty_o        = ~w_not_empty;
    assign io.credit_stall_o = w_stall;
    assign io.sent_count_o   = r_sent_count;
    assign io.stall_count_o  = r_stall_count;
endmodule

// File: tb/tb_bsg_manycore_loader_out_throttle.sv
// Directed plus randomized bench for the loader out-throttle, checked against a queue-based model.
module tb_bsg_manycore_loader_out_throttle;
    localparam int PW  = 16;
    localparam int CW  = 4;
    localparam int ELS = 4;
    localparam int RES = 1;
    localparam int NW  = 32;
    localparam longint SAT = (64'd1 << NW) - 1;

    logic clk_i = 1'b0;
    logic reset_n_i;
    always #5 clk_i = ~clk_i;

    bsg_manycore_loader_out_throttle_if #(
        .packet_width_p(PW), .credit_counter_width_p(CW), .count_width_p(NW)
    ) bus ();

    bsg_manycore_loader_out_throttle #(
        .packet_width_p(PW), .credit_counter_width_p(CW), .els_p(ELS),
        .credit_reserve_p(RES), .count_width_p(NW)
    ) u_dut (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .io(bus.slave)
    );

    int total = 0;
    int bad = 0;

    logic [PW-1:0] q[$];
    longint m_sent;
    longint m_stall;
    bit     m_rst_n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit cok;
        bit exp_v;
        cok   = m_rst_n && (int'(bus.out_credits_i) > RES);
        exp_v = (q.size() != 0) && cok;
        chk("ready_o", 64'(bus.ready_o), 64'(m_rst_n && (q.size() < ELS)));
        chk("v_o", 64'(bus.v_o), 64'(exp_v));
        chk("packet_o", 64'(bus.packet_o), exp_v ? 64'(q[0]) : 64'd0);
        chk("empty_o", 64'(bus.empty_o), 64'(q.size() == 0));
        chk("credit_stall_o", 64'(bus.credit_stall_o), 64'((q.size() != 0) && !cok));
        chk("sent_count_o", 64'(bus.sent_count_o), 64'(m_sent));
        chk("stall_count_o", 64'(bus.stall_count_o), 64'(m_stall));
    endtask

    // One clock: drive at the falling edge, check, then advance the model at the rising edge.
    task automatic step(input bit v, input logic [PW-1:0] p, input bit r,
                        input logic [CW-1:0] c, output bit enq);
        bit deq;
        bit stall;
        bit cok;
        bus.v_i = v;
        bus.packet_i = p;
        bus.ready_i = r;
        bus.out_credits_i = c;
        #1;
        check_outputs();
        cok   = int'(c) > RES;
        enq   = v && (q.size() < ELS);
        deq   = (q.size() != 0) && cok && r;
        stall = (q.size() != 0) && !cok;
        @(posedge clk_i);
        if (deq) begin
            void'(q.pop_front());
            if (m_sent != SAT) m_sent++;
        end
        if (stall && m_stall != SAT) m_stall++;
        if (enq) q.push_back(p);
        @(negedge clk_i);
    endtask

    task automatic do_reset_model();
        m_rst_n = 1'b0;
        q.delete();
        m_sent = 0;
        m_stall = 0;
    endtask

    initial begin
        bit e;
        int pushed;
        longint sent_base;

        reset_n_i = 1'b0;
        bus.v_i = 1'b0;
        bus.packet_i = '0;
        bus.ready_i = 1'b0;
        bus.out_credits_i = '0;
        do_reset_model();

        // Reset and idle
        @(negedge clk_i);
        repeat (5) begin
            #1;
            check_outputs();
            @(negedge clk_i);
        end
        reset_n_i = 1'b1;
        m_rst_n = 1'b1;
        step(0, '0, 0, 4'd10, e);

        // Fill and drain
        for (int i = 0; i < 4; i++) step(1, PW'(16'hA + i), 0, 4'd10, e);
        chk("full_ready_low", 64'(bus.ready_o), 64'd0);
        step(1, 16'hEE, 0, 4'd10, e);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 4'd10, e);
        chk("drain_sent_count", 64'(bus.sent_count_o), 64'd4);
        chk("drain_empty", 64'(bus.empty_o), 64'd1);

        // Credit reserve boundary
        step(1, 16'h11, 0, 4'd10, e);
        step(1, 16'h12, 0, 4'd10, e);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 4'd1, e);
        chk("reserve_stall_count", 64'(bus.stall_count_o), 64'd3);
        step(0, '0, 1, 4'd0, e);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 4'd2, e);
        chk("reserve_sent_count", 64'(bus.sent_count_o), 64'd6);
        chk("reserve_stall_frozen", 64'(bus.stall_count_o), 64'd4);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) step(1, PW'(16'h20 + i), 0, 4'd10, e);
        step(1, 16'h55, 1, 4'd10, e);
        chk("full_simul_no_enq", 64'(e), 64'd0);
        step(1, 16'h55, 0, 4'd10, e);
        chk("after_full_enq", 64'(e), 64'd1);
        for (int i = 0; i < 5; i++) step(0, '0, 1, 4'd10, e);

        // Wrap-around stream with random gaps
        sent_base = m_sent;
        pushed = 0;
        for (int k = 0; k < 300 && (pushed < 11 || q.size() != 0); k++) begin
            step(($urandom_range(0, 1) == 1) && (pushed < 11), PW'(16'h300 + pushed),
                 $urandom_range(0, 2) != 0, CW'($urandom_range(0, 10)), e);
            if (e) pushed++;
        end
        chk("wrap_sent_delta", 64'(bus.sent_count_o), 64'(sent_base + 11));

        // Mid-operation reset
        for (int i = 0; i < 3; i++) step(1, PW'(16'h40 + i), 0, 4'd10, e);
        for (int i = 0; i < 2; i++) step(0, '0, 0, 4'd0, e);
        reset_n_i = 1'b0;
        do_reset_model();
        #1;
        check_outputs();
        @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        m_rst_n = 1'b1;
        step(1, 16'h77, 0, 4'd10, e);
        step(1, 16'h78, 0, 4'd10, e);
        step(0, '0, 1, 4'd10, e);
        step(0, '0, 1, 4'd10, e);
        chk("post_reset_sent", 64'(bus.sent_count_o), 64'd2);

        // Fully random traffic
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 1) == 1, PW'($urandom), $urandom_range(0, 3) != 0,
                 CW'($urandom_range(0, 4)), e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
